serial_comp_unit: RTL

SERIAL_COMP_UNIT -- requirements
Module: serial_comp_unit

---
 rtl/serial_comp_unit.sv | 101 ++++++++++
 1 files changed

// File: rtl/serial_comp_unit.sv
// Bit-serial complement unit: pass, two's or one's complement of an LSB-first
// operand, with a registered serial result and a parallel word + overflow flag.
module serial_comp_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic             out_bit,
    output logic             word_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COPY,
        S_INV
    } state_t;

    typedef enum logic [1:0] {
        M_PASS = 2'b00,
        M_TWOS = 2'b01,
        M_ONES = 2'b10,
        M_RSVD = 2'b11
    } mode_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    mode_t            mode_q, mode_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             out_bit_q, out_valid_q, word_valid_q, ovf_q, ovf_d;
    logic [WIDTH-1:0] word_out_q;
    logic             res;
    logic             last;

    always_comb begin
        // Mode is taken live only on bit 0; afterwards the latched copy governs.
        mode_d = (cnt_q == '0) ? mode_t'(mode) : mode_q;
        last   = (cnt_q == LAST);

        case (mode_d)
            M_TWOS:  res = (state_q == S_INV) ? ~in_bit : in_bit;
            M_ONES:  res = ~in_bit;
            default: res = in_bit;
        endcase

        if (last)
            state_d = S_IDLE;
        else if (state_q == S_INV)
            state_d = S_INV;
        else
            state_d = in_bit ? S_INV : S_COPY;

        cnt_d   = last ? '0 : cnt_q + 1'b1;
        shift_d = {res, shift_q[WIDTH-1:1]};
        // Operand is the most-negative value: only the MSB is set.
        ovf_d   = (mode_d == M_TWOS) && (state_q != S_INV) && in_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mode_q       <= M_PASS;
            shift_q      <= '0;
            out_bit_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            word_valid_q <= 1'b0;
            word_out_q   <= '0;
            ovf_q        <= 1'b0;
        end else begin
            out_valid_q  <= in_valid;
            word_valid_q <= in_valid && last;
            if (in_valid) begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                mode_q    <= mode_d;
                shift_q   <= shift_d;
                out_bit_q <= res;
                if (last) begin
                    word_out_q <= shift_d;
                    ovf_q      <= ovf_d;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_bit    = out_bit_q;
    assign word_valid = word_valid_q;
    assign word_out   = word_out_q;
    assign ovf        = ovf_q;

endmodule
